fnd_controller: RTL and testbench

Downstream consumer of the 0–9999 up/down counter. Takes the 14-bit binary `count`, converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine, and drives a 4-digit common-anode 7-segment (FND) display by time-multiplexing one digit at a time. All outputs are registered. The block is the last stage before the board's FND pins.

---
 rtl/fnd_controller_if.sv | 16 +
 rtl/fnd_controller.sv | 175 +++++++++++++++++
 tb/tb_fnd_controller.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fnd_controller_if.sv
// rtl/fnd_controller_if.sv - Count input and FND pin bundle for fnd_controller
//
// Purpose : groups the value-in / display-out signals of fnd_controller.
// Signals : count    [13:0] binary value from the up/down counter (0..9999)
//           fnd_comm [3:0]  digit enables, active-low, bit i = digit i
//           fnd_font [7:0]  segments, active-low, [6:0] = g..a, [7] = dp
// Modports: master - drives count, observes the display pins
//           slave  - the controller itself
interface fnd_controller_if;
  logic [13:0] count;
  logic [3:0]  fnd_comm;
  logic [7:0]  fnd_font;

  modport master (output count, input fnd_comm, input fnd_font);
  modport slave  (input count, output fnd_comm, output fnd_font);
endinterface

// File: rtl/fnd_controller.sv
// rtl/fnd_controller.sv - Binary to BCD converter and 4-digit FND scan driver
//
// Purpose : converts the 14-bit count to four BCD digits with a sequential
//           double-dabble engine (14 shift cycles) and time-multiplexes the
//           digits onto a common-anode 7-segment display. Outputs registered.
// Ports   : clk   - system clock, rising edge
//           reset - asynchronous, active-high
//           bus   - fnd_controller_if.slave (count in, fnd_comm/fnd_font out)
// Params  : CLK_HZ, SCAN_HZ - per-digit hold time is CLK_HZ/SCAN_HZ cycles (>= 2)
// Config  : FND_LZ_BLANK_EN - when defined, leading zero digits are blanked
//           (digit 0 is always shown).
module fnd_controller #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic             clk,
  input  logic             reset,
  fnd_controller_if.slave  bus
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [13:0] r_last_count;
  logic [13:0] r_shift;
  logic [15:0] r_acc;
  logic [3:0]  r_iter;
  logic [15:0] r_bcd;
  logic [PW-1:0] r_presc;
  logic [1:0]  r_idx;
  logic [3:0]  r_comm;
  logic [7:0]  r_font;

  logic [13:0] w_sat;
  logic [15:0] w_adj;
  logic [3:0]  w_digit;
  logic        w_blank;
  logic [7:0]  w_seg;
  logic        w_tick;

  assign w_sat  = (bus.count > 14'd9999) ? 14'd9999 : bus.count;
  assign w_tick = (r_presc == PW'(DIV - 1));

  // Add-3 correction on every nibble that would overflow a BCD digit when doubled.
  always_comb begin
    w_adj = r_acc;
    for (int k = 0; k < 4; k++) begin
      if (r_acc[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_acc[4*k +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Conversion FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.count != r_last_count) w_state_next = SHIFT;
      SHIFT:   if (r_iter == 4'd13) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Conversion datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_count <= '0;
      r_shift      <= '0;
      r_acc        <= '0;
      r_iter       <= '0;
      r_bcd        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.count != r_last_count) begin
            // Raw value is remembered so an out-of-range count is not reconverted forever.
            r_last_count <= bus.count;
            r_shift      <= w_sat;
            r_acc        <= '0;
            r_iter       <= '0;
          end
        end
        SHIFT: begin
          r_acc   <= (w_adj << 1) | {15'd0, r_shift[13]};
          r_shift <= {r_shift[12:0], 1'b0};
          r_iter  <= r_iter + 4'd1;
        end
        DONE: begin
          r_bcd <= r_acc;
        end
        default: ;
      endcase
    end
  end

  // Scan prescaler and digit index; free-running, independent of conversion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      if (w_tick) begin
        r_presc <= '0;
        r_idx   <= r_idx + 2'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
    end
  end

  assign w_digit = r_bcd[{r_idx, 2'b00} +: 4];

`ifdef FND_LZ_BLANK_EN
  // A digit is blank when it and every higher digit are zero.
  always_comb begin
    w_blank = 1'b0;
    case (r_idx)
      2'd3: w_blank = (r_bcd[15:12] == 4'd0);
      2'd2: w_blank = (r_bcd[15:8]  == 8'd0);
      2'd1: w_blank = (r_bcd[15:4]  == 12'd0);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    w_seg = 8'hFF;
    if (!w_blank) begin
      case (w_digit)
        4'd0: w_seg = 8'hC0;
        4'd1: w_seg = 8'hF9;
        4'd2: w_seg = 8'hA4;
        4'd3: w_seg = 8'hB0;
        4'd4: w_seg = 8'h99;
        4'd5: w_seg = 8'h92;
        4'd6: w_seg = 8'h82;
        4'd7: w_seg = 8'hF8;
        4'd8: w_seg = 8'h80;
        4'd9: w_seg = 8'h90;
        default: w_seg = 8'hFF;
      endcase
    end
  end

  // Output register: one-cycle lag behind r_bcd / r_idx.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_comm <= 4'b1111;
      r_font <= 8'hFF;
    end else begin
      r_comm <= ~(4'b0001 << r_idx);
      r_font <= w_seg;
    end
  end

  assign bus.fnd_comm = r_comm;
  assign bus.fnd_font = r_font;

endmodule

// File: tb/tb_fnd_controller.sv
// tb/tb_fnd_controller.sv - Self-checking bench for fnd_controller
//
// Purpose : decimal-level reference model (value latched when idle, committed
//           15 cycles later; digit i scanned for cycles [10i,10i+10) of a frame)
//           compared every cycle, plus literal expectations on key points.
// Config  : honours FND_LZ_BLANK_EN like the design.
module tb_fnd_controller;

  localparam int DIV = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  fnd_controller_if ifc ();

  fnd_controller #(.CLK_HZ(100), .SCAN_HZ(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [7:0] SEG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  localparam int P10 [4] = '{1, 10, 100, 1000};

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] font_of(input int v, input int i);
    int d;
    d = (v / P10[i]) % 10;
`ifdef FND_LZ_BLANK_EN
    if (i > 0 && v < P10[i]) return 8'hFF;
`endif
    return SEG[d];
  endfunction

  function automatic logic [15:0] to_hex(input int v);
    logic [15:0] h;
    h[15:12] = 4'((v / 1000) % 10);
    h[11:8]  = 4'((v / 100) % 10);
    h[7:4]   = 4'((v / 10) % 10);
    h[3:0]   = 4'(v % 10);
    return h;
  endfunction

  // Reference model
  int          m_last  = 0;
  int          m_pend  = 0;
  int          m_val   = 0;
  int          m_busy  = 0;
  int          m_phase = 0;
  logic [3:0]  exp_comm = 4'hF;
  logic [7:0]  exp_font = 8'hFF;
  logic [15:0] exp_hex  = 16'h0000;
  logic [3:0]  one_hot;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_last = 0; m_pend = 0; m_val = 0; m_busy = 0; m_phase = 0;
      exp_comm = 4'hF;
      exp_font = 8'hFF;
    end else begin
      one_hot  = 4'b0001 << (m_phase / DIV);
      exp_comm = ~one_hot;
      exp_font = font_of(m_val, m_phase / DIV);
      if (m_busy == 0) begin
        if (int'(ifc.count) != m_last) begin
          m_last = int'(ifc.count);
          m_pend = (m_last > 9999) ? 9999 : m_last;
          m_busy = 15;
        end
      end else begin
        m_busy--;
        if (m_busy == 0) m_val = m_pend;
      end
      m_phase = (m_phase + 1) % (4 * DIV);
    end
    exp_hex = to_hex(m_val);
  end

  always @(negedge clk) begin
    check("cyc_comm", {12'd0, ifc.fnd_comm}, {12'd0, exp_comm});
    check("cyc_font", {8'd0, ifc.fnd_font}, {8'd0, exp_font});
    check("cyc_bcd", dut.r_bcd, exp_hex);
  end

  task automatic wait_bcd(input logic [15:0] v, input int maxc, input string name);
    for (int c = 0; c < maxc; c++) begin
      @(negedge clk);
      if (dut.r_bcd == v) break;
    end
    check(name, dut.r_bcd, v);
  endtask

  task automatic check_digit(input int i, input logic [7:0] exp, input string name);
    logic [3:0] sel;
    logic [3:0] oh;
    oh  = 4'b0001 << i;
    sel = ~oh;
    for (int c = 0; c < 6 * DIV; c++) begin
      @(negedge clk);
      if (ifc.fnd_comm == sel) break;
    end
    check({name, "_sel"}, {12'd0, ifc.fnd_comm}, {12'd0, sel});
    check(name, {8'd0, ifc.fnd_font}, {8'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.count = 14'd0;
    repeat (3) @(negedge clk);
    check("rst_comm", {12'd0, ifc.fnd_comm}, 16'h000F);
    check("rst_font", {8'd0, ifc.fnd_font}, 16'h00FF);
    #2 reset = 1'b0;
    @(negedge clk);
    check("first_comm", {12'd0, ifc.fnd_comm}, 16'h000E);
    check("first_font", {8'd0, ifc.fnd_font}, 16'h00C0);
    repeat (9) @(negedge clk);
    check("hold_comm", {12'd0, ifc.fnd_comm}, 16'h000E);
    @(negedge clk);
    check("step_comm", {12'd0, ifc.fnd_comm}, 16'h000D);

    // 1234: exact conversion latency
    ifc.count = 14'd1234;
    repeat (15) @(negedge clk);
    check("lat_before", dut.r_bcd, 16'h0000);
    @(negedge clk);
    check("lat_after", dut.r_bcd, 16'h1234);
    check("model_1234", 16'(m_val), 16'd1234);
    check_digit(0, 8'h99, "d0_1234");
    check_digit(1, 8'hB0, "d1_1234");
    check_digit(2, 8'hA4, "d2_1234");
    check_digit(3, 8'hF9, "d3_1234");

    // Saturation
    ifc.count = 14'd12000;
    repeat (20) @(negedge clk);
    check("sat_12000", dut.r_bcd, 16'h9999);
    for (int i = 0; i < 4; i++) check_digit(i, 8'h90, "d_sat");
    ifc.count = 14'd16383;
    repeat (20) @(negedge clk);
    check("sat_16383", dut.r_bcd, 16'h9999);
    check("model_last", 16'(m_last), 16'd16383);

    // Change mid-SHIFT
    ifc.count = 14'd5;
    repeat (5) @(negedge clk);
    ifc.count = 14'd7;
    wait_bcd(16'h0005, 31, "mid_first");
    wait_bcd(16'h0007, 31, "mid_second");

    // Leading zeros
    ifc.count = 14'd42;
    repeat (20) @(negedge clk);
    check("bcd_42", dut.r_bcd, 16'h0042);
`ifdef FND_LZ_BLANK_EN
    check_digit(3, 8'hFF, "d3_42");
    check_digit(2, 8'hFF, "d2_42");
`else
    check_digit(3, 8'hC0, "d3_42");
    check_digit(2, 8'hC0, "d2_42");
`endif
    check_digit(1, 8'h99, "d1_42");
    check_digit(0, 8'hA4, "d0_42");
    ifc.count = 14'd0;
    repeat (20) @(negedge clk);
    check_digit(0, 8'hC0, "d0_0");
`ifdef FND_LZ_BLANK_EN
    check_digit(1, 8'hFF, "d1_0");
    check_digit(3, 8'hFF, "d3_0");
`else
    check_digit(1, 8'hC0, "d1_0");
    check_digit(3, 8'hC0, "d3_0");
`endif

    // Reset during conversion of 9999
    ifc.count = 14'd9999;
    repeat (7) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_comm", {12'd0, ifc.fnd_comm}, 16'h000F);
    check("mid_rst_font", {8'd0, ifc.fnd_font}, 16'h00FF);
    check("mid_rst_bcd", dut.r_bcd, 16'h0000);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("post_rst_bcd", dut.r_bcd, 16'h0000);
    wait_bcd(16'h9999, 20, "reconv_9999");
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
